part_classifier: RTL and testbench

Upstream stage of the valve command path. Watches the conveyor's entry beam-break sensor and metal detector, and measures each part's blocked length in 100 µs ticks. Classifies each part and emits one `part_ready` pulse with `valve1_decision` / `valve2_decision` valid on that same cycle. These outputs connect directly to the valve command block, which queues them and fires the valves after the travel delay.

---
 rtl/sorter_pkg.sv | 18 +
 rtl/sensor_debounce.sv | 39 +++
 rtl/part_classifier.sv | 127 ++++++++++++
 tb/tb_part_classifier.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sorter_pkg.sv
// Shared types and constants for the part sorter datapath.
// Pure declarations: no latency, no flow control.
package sorter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BLOCKED  = 3'd1,
        ST_CLASSIFY = 3'd2,
        ST_EMIT     = 3'd3,
        ST_JAM      = 3'd4
    } state_t;

    localparam int TICK_DIV_DEFAULT = 5000;

    // Matches the travel counter width of the downstream valve command path.
    localparam int LEN_W = 15;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stability filter with a registered level output.
// Latency: 2 sync cycles + DEB_CYCLES cycles per accepted change; no backpressure.
module sensor_debounce #(
    parameter int DEB_CYCLES = 2500
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            stable_cnt <= '0;
            level      <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any sample agreeing with the held level restarts the run.
            if (sync2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                level      <= sync2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/part_classifier.sv
// Measures each part's blocked length in ticks and emits one classified part_ready pulse.
// Latency: debounced beam fall to part_ready = 2 cycles; no backpressure, pulse is fire-and-forget.
module part_classifier
    import sorter_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int DEB_CYCLES = 2500,
    parameter int SHORT_MAX  = 200,
    parameter int LEN_MAX    = 2000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beam_raw,
    input  logic             metal_raw,
    output logic             part_ready,
    output logic             valve1_decision,
    output logic             valve2_decision,
    output logic [LEN_W-1:0] part_len,
    output logic [15:0]      part_count,
    output logic             jam
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]    TICK_RELOAD = TW'(TICK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_LIMIT   = LEN_W'(LEN_MAX);
    localparam logic [LEN_W-1:0] SHORT_LIMIT = LEN_W'(SHORT_MAX);

    logic             beam_lvl;
    logic             metal_s1;
    logic             metal_s2;
    logic [TW-1:0]    tick_cnt;
    logic             tick;
    state_t           state;
    logic [LEN_W-1:0] len_cnt;
    logic [LEN_W-1:0] len_next;
    logic             metal_seen;

    sensor_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_beam_deb (
        .clk   (clk),
        .rst   (rst),
        .raw   (beam_raw),
        .level (beam_lvl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            metal_s1 <= 1'b0;
            metal_s2 <= 1'b0;
        end else begin
            metal_s1 <= metal_raw;
            metal_s2 <= metal_s1;
        end
    end

    // Free-running: part boundaries never realign the tick phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= TICK_RELOAD;
        end else if (tick_cnt == '0) begin
            tick_cnt <= TICK_RELOAD;
        end else begin
            tick_cnt <= tick_cnt - 1'b1;
        end
    end

    assign tick     = (tick_cnt == '0);
    assign len_next = len_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            len_cnt         <= '0;
            metal_seen      <= 1'b0;
            part_ready      <= 1'b0;
            valve1_decision <= 1'b0;
            valve2_decision <= 1'b0;
            part_len        <= '0;
            part_count      <= '0;
            jam             <= 1'b0;
        end else begin
            part_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (beam_lvl) begin
                        state      <= ST_BLOCKED;
                        len_cnt    <= '0;
                        metal_seen <= 1'b0;
                    end
                end
                ST_BLOCKED: begin
                    metal_seen <= metal_seen | metal_s2;
                    if (tick) begin
                        len_cnt <= len_next;
                    end
                    if (tick && (len_next >= LEN_LIMIT)) begin
                        state <= ST_JAM;
                        jam   <= 1'b1;
                    end else if (!beam_lvl) begin
                        state <= ST_CLASSIFY;
                    end
                end
                ST_CLASSIFY: begin
                    // Outputs land together so the pulse cycle carries its decisions.
                    valve2_decision <= metal_seen;
                    valve1_decision <= !metal_seen && (len_cnt < SHORT_LIMIT);
                    part_len        <= len_cnt;
                    part_ready      <= 1'b1;
                    part_count      <= part_count + 16'd1;
                    state           <= ST_EMIT;
                end
                ST_EMIT: begin
                    state <= ST_IDLE;
                end
                ST_JAM: begin
                    if (!beam_lvl) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_part_classifier.sv
// Directed bench for part_classifier with a queue-based part model and per-cycle output compare.
module tb_part_classifier;
    localparam int TICK_DIV   = 10;
    localparam int DEB_CYCLES = 4;
    localparam int SHORT_MAX  = 5;
    localparam int LEN_MAX    = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        beam_raw;
    logic        metal_raw;
    logic        part_ready;
    logic        valve1_decision;
    logic        valve2_decision;
    logic [14:0] part_len;
    logic [15:0] part_count;
    logic        jam;

    typedef struct packed {
        logic        v1;
        logic        v2;
        logic [14:0] len;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t cur;
    int   model_count;
    bit   jam_allowed;
    bit   mon_en;
    logic jam_prev;
    int   lat;

    part_classifier #(
        .TICK_DIV   (TICK_DIV),
        .DEB_CYCLES (DEB_CYCLES),
        .SHORT_MAX  (SHORT_MAX),
        .LEN_MAX    (LEN_MAX)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .beam_raw        (beam_raw),
        .metal_raw       (metal_raw),
        .part_ready      (part_ready),
        .valve1_decision (valve1_decision),
        .valve2_decision (valve2_decision),
        .part_len        (part_len),
        .part_count      (part_count),
        .jam             (jam)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Length in ticks equals blocked cycles / TICK_DIV when the blocked span is a whole number of periods.
    task automatic run_part(input int cycles, input logic metal);
        int len;
        len = cycles / TICK_DIV;
        if (len >= LEN_MAX) jam_allowed = 1'b1;
        else exp_q.push_back(exp_t'{v1: (len < SHORT_MAX) && !metal, v2: metal, len: 15'(len)});
        beam_raw = 1'b1;
        step(cycles / 2);
        metal_raw = metal;
        step(2);
        metal_raw = 1'b0;
        step(cycles - cycles / 2 - 2);
        beam_raw = 1'b0;
        step(25);
        chk("pulse_delivered", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (part_ready) begin
                chk("pulse_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    model_count++;
                end
            end
            chk("valve1", valve1_decision, cur.v1);
            chk("valve2", valve2_decision, cur.v2);
            chk("part_len", part_len, cur.len);
            chk("part_count", part_count, 16'(model_count));
            if (!jam_allowed) chk("jam_early", jam, 0);
            if (jam_prev) chk("jam_sticky", jam, 1);
            jam_prev = jam;
        end
    end

    initial begin
        rst         = 1'b1;
        beam_raw    = 1'b1;
        metal_raw   = 1'b0;
        mon_en      = 1'b0;
        cur         = '0;
        model_count = 0;
        jam_allowed = 1'b0;
        jam_prev    = 1'b0;

        step(3);
        chk("rst_part_ready", part_ready, 0);
        chk("rst_valve1", valve1_decision, 0);
        chk("rst_valve2", valve2_decision, 0);
        chk("rst_part_len", part_len, 0);
        chk("rst_part_count", part_count, 0);
        chk("rst_jam", jam, 0);

        // Short part: beam already blocked through reset, held 30 cycles after release.
        rst    = 1'b0;
        mon_en = 1'b1;
        exp_q.push_back(exp_t'{v1: 1'b1, v2: 1'b0, len: 15'd3});
        step(30);
        beam_raw = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (part_ready) begin
                lat = k;
                break;
            end
        end
        chk("short_latency", lat, 8);
        step(15);
        chk("short_len", part_len, 3);
        chk("short_v1", valve1_decision, 1);
        chk("short_v2", valve2_decision, 0);
        chk("short_count", part_count, 1);

        run_part(120, 1'b1);
        chk("metal_len", part_len, 12);
        chk("metal_v1", valve1_decision, 0);
        chk("metal_v2", valve2_decision, 1);

        run_part(100, 1'b0);
        chk("long_len", part_len, 10);
        chk("long_v1", valve1_decision, 0);
        chk("long_v2", valve2_decision, 0);
        chk("long_count", part_count, 3);

        beam_raw = 1'b1;
        step(3);
        beam_raw = 1'b0;
        step(25);
        chk("glitch_count", part_count, 3);
        chk("glitch_jam", jam, 0);

        run_part(250, 1'b0);
        chk("jam_set", jam, 1);
        chk("jam_count", part_count, 3);

        run_part(30, 1'b0);
        chk("after_jam_count", part_count, 4);
        chk("after_jam_len", part_len, 3);
        chk("after_jam_v1", valve1_decision, 1);
        chk("after_jam_flag", jam, 1);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
